// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hazard_scoreboard_if                                            |
// | Purpose  : Decode/bypass/writeback/exception bundle for hazard_scoreboard.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface hazard_scoreboard_if #(
    parameter int ISSUE_W = 2,
    parameter int NBYP    = 3,
    parameter int NWB     = 2,
    parameter int CNT_W   = 16,
    parameter int SELW    = $clog2(NBYP + 1)
);
    logic [ISSUE_W-1:0]      dec_valid;
    logic [ISSUE_W*5-1:0]    dec_rs;
    logic [ISSUE_W*5-1:0]    dec_rt;
    logic [ISSUE_W-1:0]      dec_wr;
    logic [ISSUE_W*5-1:0]    dec_waddr;
    logic [ISSUE_W-1:0]      dec_long;
    logic [NBYP-1:0]         byp_valid;
    logic [NBYP*5-1:0]       byp_waddr;
    logic [NBYP-1:0]         byp_ready;
    logic [NWB-1:0]          wb_valid;
    logic [NWB*5-1:0]        wb_waddr;
    logic                    ext_stall;
    logic                    except_i;
    logic [31:0]             excepttype;
    logic [31:0]             epc;
    logic [ISSUE_W-1:0]      issue_mask;
    logic [ISSUE_W*SELW-1:0] fwd_rs;
    logic [ISSUE_W*SELW-1:0] fwd_rt;
    logic                    stall_dec;
    logic                    flush;
    logic                    redirect_vld;
    logic [31:0]             redirect_pc;
    logic [CNT_W-1:0]        stall_cnt;

    modport master (
        output dec_valid, dec_rs, dec_rt, dec_wr, dec_waddr, dec_long,
        output byp_valid, byp_waddr, byp_ready, wb_valid, wb_waddr,
        output ext_stall, except_i, excepttype, epc,
        input  issue_mask, fwd_rs, fwd_rt, stall_dec, flush,
        input  redirect_vld, redirect_pc, stall_cnt
    );

    modport slave (
        input  dec_valid, dec_rs, dec_rt, dec_wr, dec_waddr, dec_long,
        input  byp_valid, byp_waddr, byp_ready, wb_valid, wb_waddr,
        input  ext_stall, except_i, excepttype, epc,
        output issue_mask, fwd_rs, fwd_rt, stall_dec, flush,
        output redirect_vld, redirect_pc, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hazard_scoreboard                                               |
// | Purpose  : Busy scoreboard, operand bypass select, bundle split, stall and  |
// |            exception redirect for a multi-issue decode stage.              |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module hazard_scoreboard #(
    parameter int          ISSUE_W = 2,
    parameter int          NBYP    = 3,
    parameter int          NWB     = 2,
    parameter logic [31:0] EXC_VEC = 32'hBFC00380,
    parameter int          CNT_W   = 16
) (
    input  wire logic          clk,
    input  wire logic          resetn,
    hazard_scoreboard_if.slave bus
);
    localparam int SELW = $clog2(NBYP + 1);
    localparam logic [31:0] C_EXC_CODE_ERET = 32'h0000_000E;

    logic [31:0]             r_busy;
    logic [31:0]             w_busy_nxt;
    logic [31:0]             w_wb_clr;
    logic [31:0]             w_pend;
    logic [ISSUE_W-1:0]      w_haz;
    logic [ISSUE_W-1:0]      w_issue;
    logic [ISSUE_W*SELW-1:0] w_fwd_rs;
    logic [ISSUE_W*SELW-1:0] w_fwd_rt;
    logic                    w_ok;
    logic                    w_stall;
    logic                    r_redirect_vld;
    logic [31:0]             r_redirect_pc;
    logic [CNT_W-1:0]        r_stall_cnt;

    // Returns {hazard, select}; the lowest-index matching bypass wins.
    function automatic logic [SELW:0] lookup(
        input logic [4:0]        src,
        input logic [NBYP-1:0]   bv,
        input logic [NBYP*5-1:0] bw,
        input logic [NBYP-1:0]   br,
        input logic [31:0]       pend
    );
        logic [SELW:0] res;
        res = '0;
        if (src != 5'd0) begin
            res = {pend[src], {SELW{1'b0}}};
            for (int k = NBYP - 1; k >= 0; k--) begin
                if (bv[k] && (bw[k*5 +: 5] == src)) begin
                    res = br[k] ? {1'b0, SELW'(k + 1)} : {1'b1, {SELW{1'b0}}};
                end
            end
        end
        return res;
    endfunction

    always_comb begin
        w_wb_clr = '0;
        for (int p = 0; p < NWB; p++) begin
            if (bus.wb_valid[p]) begin
                w_wb_clr[bus.wb_waddr[p*5 +: 5]] = 1'b1;
            end
        end
    end

    // A writeback landing this cycle resolves the busy bit in time for decode.
    assign w_pend = r_busy & ~w_wb_clr;

    generate
        for (genvar s = 0; s < ISSUE_W; s++) begin : g_slot
            logic [SELW:0] w_lk_rs;
            logic [SELW:0] w_lk_rt;
            logic          w_intra;

            assign w_lk_rs = lookup(bus.dec_rs[s*5 +: 5], bus.byp_valid, bus.byp_waddr,
                                    bus.byp_ready, w_pend);
            assign w_lk_rt = lookup(bus.dec_rt[s*5 +: 5], bus.byp_valid, bus.byp_waddr,
                                    bus.byp_ready, w_pend);

            always_comb begin
                w_intra = 1'b0;
                for (int i = 0; i < s; i++) begin
                    if (bus.dec_valid[i] && bus.dec_wr[i] && (bus.dec_waddr[i*5 +: 5] != 5'd0) &&
                        ((bus.dec_waddr[i*5 +: 5] == bus.dec_rs[s*5 +: 5]) ||
                         (bus.dec_waddr[i*5 +: 5] == bus.dec_rt[s*5 +: 5]))) begin
                        w_intra = 1'b1;
                    end
                end
            end

            assign w_haz[s]                = w_lk_rs[SELW] | w_lk_rt[SELW] | w_intra;
            assign w_fwd_rs[s*SELW +: SELW] = w_lk_rs[SELW-1:0];
            assign w_fwd_rt[s*SELW +: SELW] = w_lk_rt[SELW-1:0];
        end
    endgenerate

    // Issue is a contiguous prefix: the first blocked slot blocks all younger ones.
    always_comb begin
        w_issue = '0;
        w_ok    = ~bus.ext_stall & ~bus.except_i;
        for (int s = 0; s < ISSUE_W; s++) begin
            w_ok       = w_ok & bus.dec_valid[s] & ~w_haz[s];
            w_issue[s] = w_ok;
        end
        w_stall = bus.ext_stall | (|(bus.dec_valid & ~w_issue));
    end

    // Sets are applied after clears so a younger long writer keeps its register busy.
    always_comb begin
        w_busy_nxt = r_busy & ~w_wb_clr;
        for (int s = 0; s < ISSUE_W; s++) begin
            if (w_issue[s] && bus.dec_wr[s] && bus.dec_long[s] &&
                (bus.dec_waddr[s*5 +: 5] != 5'd0)) begin
                w_busy_nxt[bus.dec_waddr[s*5 +: 5]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_busy         <= '0;
            r_redirect_vld <= 1'b0;
            r_redirect_pc  <= EXC_VEC;
            r_stall_cnt    <= '0;
        end else begin
            if (bus.except_i) begin
                r_busy         <= '0;
                r_redirect_vld <= 1'b1;
                r_redirect_pc  <= (bus.excepttype == C_EXC_CODE_ERET) ? bus.epc : EXC_VEC;
            end else begin
                r_busy         <= w_busy_nxt;
                r_redirect_vld <= 1'b0;
            end
            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign bus.issue_mask   = w_issue;
    assign bus.fwd_rs       = w_fwd_rs;
    assign bus.fwd_rt       = w_fwd_rt;
    assign bus.stall_dec    = w_stall;
    assign bus.flush        = bus.except_i;
    assign bus.redirect_vld = r_redirect_vld;
    assign bus.redirect_pc  = r_redirect_pc;
    assign bus.stall_cnt    = r_stall_cnt;
endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_hazard_scoreboard                                            |
// | Purpose  : Vector table, directed corner sequences and random run checked   |
// |            against a register-level reference model.                       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_hazard_scoreboard;
    localparam int          ISSUE_W = 2;
    localparam int          NBYP    = 3;
    localparam int          NWB     = 2;
    localparam int          CNT_W   = 12;
    localparam logic [31:0] EXC_VEC = 32'hBFC00380;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic resetn;
    int   n_pass;
    int   n_total;

    hazard_scoreboard_if #(.ISSUE_W(ISSUE_W), .NBYP(NBYP), .NWB(NWB), .CNT_W(CNT_W)) bus ();

    hazard_scoreboard #(
        .ISSUE_W(ISSUE_W), .NBYP(NBYP), .NWB(NWB), .EXC_VEC(EXC_VEC), .CNT_W(CNT_W)
    ) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: which registers await a long-latency result, plus redirect/counter.
    bit          m_busy [32];
    bit          m_rvld;
    logic [31:0] m_rpc;
    int          m_cnt;

    typedef struct packed {
        logic [1:0]  valid;
        logic [4:0]  rs0, rt0, rs1, rt1;
        logic [1:0]  wr;
        logic [4:0]  wa0, wa1;
        logic [2:0]  bv;
        logic [14:0] bw;
        logic [2:0]  br;
        logic        ext;
        logic [1:0]  e_iss;
        logic        e_stall;
        logic [3:0]  e_frs, e_frt;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    endtask

    task automatic clr();
        bus.dec_valid = '0; bus.dec_rs = '0; bus.dec_rt = '0; bus.dec_wr = '0;
        bus.dec_waddr = '0; bus.dec_long = '0; bus.byp_valid = '0; bus.byp_waddr = '0;
        bus.byp_ready = '0; bus.wb_valid = '0; bus.wb_waddr = '0; bus.ext_stall = 1'b0;
        bus.except_i = 1'b0; bus.excepttype = '0; bus.epc = '0;
    endtask

    function automatic void model_reset();
        foreach (m_busy[r]) m_busy[r] = 1'b0;
        m_rvld = 1'b0;
        m_rpc  = EXC_VEC;
        m_cnt  = 0;
    endfunction

    function automatic void model_lookup(input logic [4:0] src, output bit haz, output int sel);
        haz = 1'b0;
        sel = 0;
        if (src == 5'd0) return;
        for (int k = 0; k < NBYP; k++) begin
            if (bus.byp_valid[k] && bus.byp_waddr[k*5 +: 5] == src) begin
                if (bus.byp_ready[k]) sel = k + 1;
                else haz = 1'b1;
                return;
            end
        end
        for (int p = 0; p < NWB; p++)
            if (bus.wb_valid[p] && bus.wb_waddr[p*5 +: 5] == src) return;
        haz = m_busy[src];
    endfunction

    function automatic void model_comb(output logic [1:0] iss, output logic [3:0] frs,
                                       output logic [3:0] frt, output bit st);
        bit blocked;
        iss = '0; frs = '0; frt = '0;
        blocked = bus.ext_stall || bus.except_i;
        for (int s = 0; s < ISSUE_W; s++) begin
            logic [4:0] rs, rt;
            bit ha, hb, hz;
            int sa, sb;
            rs = bus.dec_rs[s*5 +: 5];
            rt = bus.dec_rt[s*5 +: 5];
            model_lookup(rs, ha, sa);
            model_lookup(rt, hb, sb);
            hz = ha || hb;
            for (int i = 0; i < s; i++) begin
                logic [4:0] wa;
                wa = bus.dec_waddr[i*5 +: 5];
                if (bus.dec_valid[i] && bus.dec_wr[i] && wa != 0 && (wa == rs || wa == rt)) hz = 1'b1;
            end
            frs[s*2 +: 2] = 2'(sa);
            frt[s*2 +: 2] = 2'(sb);
            if (!blocked && bus.dec_valid[s] && !hz) iss[s] = 1'b1;
            else blocked = 1'b1;
        end
        st = bus.ext_stall || ((bus.dec_valid & ~iss) != 0);
    endfunction

    function automatic void model_update(input logic [1:0] iss, input bit st);
        if (bus.except_i) begin
            foreach (m_busy[r]) m_busy[r] = 1'b0;
            m_rvld = 1'b1;
            m_rpc  = (bus.excepttype == 32'h0E) ? bus.epc : EXC_VEC;
        end else begin
            m_rvld = 1'b0;
            for (int p = 0; p < NWB; p++)
                if (bus.wb_valid[p]) m_busy[bus.wb_waddr[p*5 +: 5]] = 1'b0;
            for (int s = 0; s < ISSUE_W; s++)
                if (iss[s] && bus.dec_wr[s] && bus.dec_long[s] && bus.dec_waddr[s*5 +: 5] != 0)
                    m_busy[bus.dec_waddr[s*5 +: 5]] = 1'b1;
        end
        if (st && m_cnt < CNT_MAX) m_cnt++;
    endfunction

    // Called just after a falling edge with inputs applied; ends at the next falling edge.
    task automatic cycle(input bit do_chk);
        logic [1:0] e_iss;
        logic [3:0] e_frs, e_frt, msk;
        bit         e_st;
        #1;
        model_comb(e_iss, e_frs, e_frt, e_st);
        if (do_chk) begin
            msk = {{2{e_iss[1]}}, {2{e_iss[0]}}};
            chk("issue_mask", 32'(bus.issue_mask), 32'(e_iss));
            chk("stall_dec", 32'(bus.stall_dec), 32'(e_st));
            chk("flush", 32'(bus.flush), 32'(bus.except_i));
            chk("fwd_rs", 32'(bus.fwd_rs & msk), 32'(e_frs & msk));
            chk("fwd_rt", 32'(bus.fwd_rt & msk), 32'(e_frt & msk));
            chk("redirect_vld", 32'(bus.redirect_vld), 32'(m_rvld));
            chk("redirect_pc", bus.redirect_pc, m_rpc);
            chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_cnt));
        end
        model_update(e_iss, e_st);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        clr();
        model_reset();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        //             valid rs0  rt0  rs1  rt1  wr    wa0  wa1  bv      bw                 br      ext  iss   st   frs      frt
        tbl[0]  = '{2'b01, 5'd7, 5'd0, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 3'b110, {5'd7, 5'd7, 5'd0}, 3'b010, 1'b0, 2'b01, 1'b0, 4'b0010, 4'b0000};
        tbl[1]  = '{2'b01, 5'd7, 5'd0, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 3'b110, {5'd7, 5'd7, 5'd0}, 3'b100, 1'b0, 2'b00, 1'b1, 4'b0000, 4'b0000};
        tbl[2]  = '{2'b11, 5'd1, 5'd2, 5'd3, 5'd4, 2'b01, 5'd3, 5'd0, 3'b000, 15'd0,              3'b000, 1'b0, 2'b01, 1'b1, 4'b0000, 4'b0000};
        tbl[3]  = '{2'b11, 5'd1, 5'd2, 5'd3, 5'd4, 2'b01, 5'd0, 5'd0, 3'b000, 15'd0,              3'b000, 1'b0, 2'b11, 1'b0, 4'b0000, 4'b0000};
        tbl[4]  = '{2'b11, 5'd1, 5'd2, 5'd5, 5'd3, 2'b01, 5'd3, 5'd0, 3'b000, 15'd0,              3'b000, 1'b0, 2'b01, 1'b1, 4'b0000, 4'b0000};
        tbl[5]  = '{2'b11, 5'd1, 5'd2, 5'd5, 5'd3, 2'b00, 5'd3, 5'd0, 3'b000, 15'd0,              3'b000, 1'b0, 2'b11, 1'b0, 4'b0000, 4'b0000};
        tbl[6]  = '{2'b11, 5'd1, 5'd2, 5'd4, 5'd5, 2'b00, 5'd0, 5'd0, 3'b000, 15'd0,              3'b000, 1'b1, 2'b00, 1'b1, 4'b0000, 4'b0000};
        tbl[7]  = '{2'b11, 5'd9, 5'd0, 5'd0, 5'd9, 2'b00, 5'd0, 5'd0, 3'b001, {5'd0, 5'd0, 5'd9}, 3'b001, 1'b0, 2'b11, 1'b0, 4'b0001, 4'b0100};
        tbl[8]  = '{2'b01, 5'd0, 5'd12, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 3'b100, {5'd12, 5'd0, 5'd0}, 3'b100, 1'b0, 2'b01, 1'b0, 4'b0000, 4'b0011};
        tbl[9]  = '{2'b01, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 3'b001, 15'd0,              3'b000, 1'b0, 2'b01, 1'b0, 4'b0000, 4'b0000};
        tbl[10] = '{2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 3'b000, 15'd0,              3'b000, 1'b0, 2'b00, 1'b0, 4'b0000, 4'b0000};
        tbl[11] = '{2'b11, 5'd1, 5'd0, 5'd7, 5'd0, 2'b00, 5'd0, 5'd0, 3'b010, {5'd0, 5'd7, 5'd0}, 3'b010, 1'b0, 2'b11, 1'b0, 4'b1000, 4'b0000};

        do_reset();
        #1;
        chk("rst_redirect_vld", 32'(bus.redirect_vld), 32'd0);
        chk("rst_redirect_pc", bus.redirect_pc, EXC_VEC);
        chk("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        chk("rst_stall_dec", 32'(bus.stall_dec), 32'd0);

        for (int i = 0; i < 12; i++) begin
            logic [3:0] msk;
            clr();
            bus.dec_valid = tbl[i].valid;
            bus.dec_rs    = {tbl[i].rs1, tbl[i].rs0};
            bus.dec_rt    = {tbl[i].rt1, tbl[i].rt0};
            bus.dec_wr    = tbl[i].wr;
            bus.dec_waddr = {tbl[i].wa1, tbl[i].wa0};
            bus.byp_valid = tbl[i].bv;
            bus.byp_waddr = tbl[i].bw;
            bus.byp_ready = tbl[i].br;
            bus.ext_stall = tbl[i].ext;
            #1;
            msk = {{2{tbl[i].e_iss[1]}}, {2{tbl[i].e_iss[0]}}};
            chk($sformatf("vec%0d_issue", i), 32'(bus.issue_mask), 32'(tbl[i].e_iss));
            chk($sformatf("vec%0d_stall", i), 32'(bus.stall_dec), 32'(tbl[i].e_stall));
            chk($sformatf("vec%0d_fwd_rs", i), 32'(bus.fwd_rs & msk), 32'(tbl[i].e_frs));
            chk($sformatf("vec%0d_fwd_rt", i), 32'(bus.fwd_rt & msk), 32'(tbl[i].e_frt));
            cycle(1'b1);
        end

        // lw r5 then a dependent addu waits for the r5 writeback
        clr();
        bus.dec_valid = 2'b01; bus.dec_wr = 2'b01; bus.dec_long = 2'b01;
        bus.dec_waddr[4:0] = 5'd5; bus.dec_rs[4:0] = 5'd1;
        #1 chk("lw_issue", 32'(bus.issue_mask), 32'b01);
        cycle(1'b1);
        clr();
        bus.dec_valid = 2'b01; bus.dec_wr = 2'b01; bus.dec_rs[4:0] = 5'd5; bus.dec_waddr[4:0] = 5'd6;
        repeat (3) begin
            #1 chk("load_use_stall", 32'(bus.stall_dec), 32'd1);
            cycle(1'b1);
        end
        bus.wb_valid = 2'b01; bus.wb_waddr[4:0] = 5'd5;
        #1;
        chk("wb_release_issue", 32'(bus.issue_mask), 32'b01);
        chk("wb_release_fwd", 32'(bus.fwd_rs[1:0]), 32'd0);
        cycle(1'b1);

        // same-cycle writeback and new long write of r9: set wins
        clr();
        bus.dec_valid = 2'b01; bus.dec_wr = 2'b01; bus.dec_long = 2'b01; bus.dec_waddr[4:0] = 5'd9;
        bus.wb_valid = 2'b10; bus.wb_waddr[9:5] = 5'd9;
        cycle(1'b1);
        clr();
        bus.dec_valid = 2'b01; bus.dec_rs[4:0] = 5'd9;
        #1 chk("busy9_set_wins", 32'(bus.stall_dec), 32'd1);
        cycle(1'b1);
        bus.wb_valid = 2'b01; bus.wb_waddr[4:0] = 5'd9;
        cycle(1'b1);
        clr();
        bus.ext_stall = 1'b1; bus.dec_valid = 2'b01; bus.dec_wr = 2'b01; bus.dec_long = 2'b01;
        bus.dec_waddr[4:0] = 5'd10;
        #1 chk("ext_stall_issue", 32'(bus.issue_mask), 32'd0);
        cycle(1'b1);
        clr();
        bus.dec_valid = 2'b01; bus.dec_rs[4:0] = 5'd10;
        #1 chk("ext_stall_busy_kept", 32'(bus.stall_dec), 32'd0);
        cycle(1'b1);

        // exception: flush, redirect to EPC for code 0x0E, vector otherwise
        clr();
        bus.dec_valid = 2'b01; bus.dec_wr = 2'b01; bus.dec_long = 2'b01; bus.dec_waddr[4:0] = 5'd5;
        cycle(1'b1);
        clr();
        bus.except_i = 1'b1; bus.excepttype = 32'h0E; bus.epc = 32'h80001234; bus.dec_valid = 2'b01;
        #1;
        chk("exc_flush", 32'(bus.flush), 32'd1);
        chk("exc_issue", 32'(bus.issue_mask), 32'd0);
        cycle(1'b1);
        clr();
        bus.dec_valid = 2'b01; bus.dec_rs[4:0] = 5'd5;
        #1;
        chk("exc_redirect_vld", 32'(bus.redirect_vld), 32'd1);
        chk("exc_redirect_epc", bus.redirect_pc, 32'h80001234);
        chk("exc_busy_cleared", 32'(bus.stall_dec), 32'd0);
        cycle(1'b1);
        clr();
        #1 chk("redirect_one_shot", 32'(bus.redirect_vld), 32'd0);
        cycle(1'b1);
        bus.except_i = 1'b1; bus.excepttype = 32'h04; bus.epc = 32'h80001234;
        cycle(1'b1);
        bus.excepttype = 32'h0E;
        #1 chk("exc_vector_pc", bus.redirect_pc, EXC_VEC);
        cycle(1'b1);
        clr();
        #1;
        chk("redirect_held", 32'(bus.redirect_vld), 32'd1);
        chk("redirect_held_pc", bus.redirect_pc, 32'h80001234);
        cycle(1'b1);

        // randomized traffic against the reference model
        for (int n = 0; n < 1500; n++) begin
            int v;
            clr();
            v = $urandom_range(0, 2);
            bus.dec_valid = (v == 0) ? 2'b00 : (v == 1) ? 2'b01 : 2'b11;
            for (int s = 0; s < ISSUE_W; s++) begin
                bus.dec_rs[s*5 +: 5]    = 5'($urandom_range(0, 7));
                bus.dec_rt[s*5 +: 5]    = 5'($urandom_range(0, 7));
                bus.dec_waddr[s*5 +: 5] = 5'($urandom_range(0, 7));
            end
            bus.dec_wr    = 2'($urandom);
            bus.dec_long  = 2'($urandom);
            bus.byp_valid = 3'($urandom);
            bus.byp_ready = 3'($urandom);
            for (int k = 0; k < NBYP; k++) bus.byp_waddr[k*5 +: 5] = 5'($urandom_range(0, 7));
            bus.wb_valid  = 2'($urandom);
            for (int p = 0; p < NWB; p++) bus.wb_waddr[p*5 +: 5] = 5'($urandom_range(0, 7));
            bus.ext_stall  = ($urandom_range(0, 7) == 0);
            bus.except_i   = ($urandom_range(0, 15) == 0);
            bus.excepttype = $urandom_range(0, 1) ? 32'h0E : 32'h04;
            bus.epc        = $urandom;
            cycle(1'b1);
        end

        // stall counter saturation
        do_reset();
        bus.ext_stall = 1'b1;
        repeat (CNT_MAX + 4) cycle(1'b0);
        #1 chk("stall_cnt_saturated", 32'(bus.stall_cnt), 32'(CNT_MAX));
        cycle(1'b1);
        clr();
        cycle(1'b1);

        // asynchronous reset while a redirect is pending
        bus.except_i = 1'b1; bus.excepttype = 32'h0E; bus.epc = 32'h80005678;
        cycle(1'b1);
        resetn = 1'b0;
        #1;
        chk("rst_mid_redirect_vld", 32'(bus.redirect_vld), 32'd0);
        chk("rst_mid_redirect_pc", bus.redirect_pc, EXC_VEC);
        chk("rst_mid_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        clr();
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        cycle(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
